scrambler_duplex: RTL and testbench
===================================

Name: scrambler_duplex

Overview:
Parametrised self-synchronising scrambler/descrambler for the 10GBASE-R PCS, implementing G(x) = 1 + x^39 + x^58 per IEEE 802.3 clause 49.2.
- Sits between the 64b/66b encoder and the gearbox (scramble mode), or between the block-sync/gearbox and the decoder (descramble mode).
- Adds over the previous generation:
  - 32/64-bit width
  - descramble mode
  - valid/ready backpressure
  - 2-bit sync-header passthrough
  - runtime bypass
  - seed load
  - descrambler priming indicator

Parameters:
- DATA_WIDTH, 32, data word width; legal values 32 or 64.
- MODE, 0, 0 = scramble, 1 = descramble.
- BYPASS, 0, 1 = permanent bypass; ORed with i_bypass.
- LFSR_SEED, 58'h3FF_FFFF_FFFF_FFFF, LFSR value after reset.

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  asynchronous, active-low reset
- i_data_valid  in  1  upstream word valid
- o_data_ready  out  1  block can accept a word this cycle
- i_data  in  DATA_WIDTH  payload; bit 0 is the first bit on the wire
- i_hdr  in  2  sync header; never scrambled
- i_bypass  in  1  runtime bypass
- i_seed_load  in  1  load i_seed into the LFSR
- i_seed  in  58  seed value
- o_data_valid  out  1  output word valid
- i_data_ready  in  1  downstream accepts the output word
- o_data  out  DATA_WIDTH  scrambled or descrambled payload
- o_hdr  out  2  header aligned with o_data
- o_primed  out  1  descrambler state is fully derived from the received stream

Behaviour:
- Interface: single clock i_clk; reset i_reset_n is asynchronous and active-low.
- Reset values:
  - o_data_valid = 0, o_data = 0, o_hdr = 0, o_primed = 0.
  - LFSR = LFSR_SEED.
  - Priming counter = 0.
- Handshake:
  - o_data_ready = !o_data_valid || i_data_ready (combinational).
  - Accept = i_data_valid && o_data_ready.
- Latency: 1 cycle. On accept, o_data, o_hdr and o_data_valid = 1 are registered.
- Output hold: when o_data_valid && !i_data_ready, o_data and o_hdr hold stable. o_data_valid clears only when the word is taken and no new word is accepted.
- LFSR update: state s[57:0], where s[0] is the most recently shifted bit. For each i = 0..DATA_WIDTH-1 in order, within one cycle:
  - f = s[38] ^ s[57]; out[i] = in[i] ^ f.
  - Scramble: s = {s[56:0], out[i]}.
  - Descramble: s = {s[56:0], in[i]}.
  - The LFSR advances only on accept.
- Bypass (BYPASS || i_bypass, sampled at accept):
  - out = in.
  - LFSR frozen.
  - Priming counter frozen.
- Seed load:
  - i_seed_load loads LFSR = i_seed and clears the priming counter and o_primed.
  - If it coincides with an accept, that word is processed with the pre-load state, but the load wins the LFSR and counter update.
- Priming (descramble only):
  - The counter increments on each non-bypass accept and saturates at P = ceil(58/DATA_WIDTH) (2 for width 32, 1 for width 64).
  - o_primed = 1 from the cycle after the counter reaches P.
  - In scramble mode o_primed = 1 one cycle after reset release.
- Header: i_hdr is copied to o_hdr unchanged and does not enter the LFSR.
- Reset asserted mid-stream: all outputs drop immediately to reset values and the in-flight word is lost. After release, the first accept uses LFSR_SEED.
- Width rule: DATA_WIDTH other than 32 or 64 is an elaboration error.

Test Plan:
1. Scramble, DATA_WIDTH = 32, default seed, i_data = 0x00000000 for 2 words, i_hdr = 2'b01 -> o_data = 0x00000000, then 0x03FFFF80. o_hdr = 2'b01 on both. Each word appears 1 cycle after its accept.
2. Backpressure: hold i_data_ready = 0 for 3 cycles with i_data_valid = 1 -> o_data_ready = 0 while the output is full; o_data stable; no word lost or duplicated; LFSR advances once per accepted word.
3. Loopback: scrambler (seed all-ones) -> descrambler (seed 0), 32-bit, random payload -> o_primed rises after 2 accepted words. Descrambler output equals the original payload from word 3 onward, and from bit 26 of word 2.
4. Bypass: i_bypass = 1 for 1 word of 0xDEADBEEF mid-stream -> o_data = 0xDEADBEEF. The next scrambled word equals the word the reference model produces when the bypassed word is skipped.
5. Seed load coincident with accept, DATA_WIDTH = 64 -> that word is scrambled with the old state. The next word uses i_seed. In descramble mode o_primed drops, then returns after 1 more word.
6. Asynchronous reset asserted between clock edges with o_data_valid = 1 -> o_data_valid = 0 immediately. After release, scrambling 0 with all-ones seed again yields 0x00000000.

Source files
------------

// File: rtl/scrambler_duplex_if.sv
// Valid/ready word channel with sync header for the 10GBASE-R scrambler.
// slave is the block's view; master is the environment driving both its input and output sides.
interface scrambler_duplex_if #(
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic                  i_data_valid;
    logic                  o_data_ready;
    logic [DATA_WIDTH-1:0] i_data;
    logic [1:0]            i_hdr;
    logic                  o_data_valid;
    logic                  i_data_ready;
    logic [DATA_WIDTH-1:0] o_data;
    logic [1:0]            o_hdr;

    modport slave (
        input  i_data_valid, i_data, i_hdr, i_data_ready,
        output o_data_ready, o_data_valid, o_data, o_hdr
    );

    modport master (
        output i_data_valid, i_data, i_hdr, i_data_ready,
        input  o_data_ready, o_data_valid, o_data, o_hdr
    );
endinterface

// File: rtl/scrambler_duplex.sv
// Self-synchronising 10GBASE-R scrambler/descrambler, G(x) = 1 + x^39 + x^58.
// One word per cycle with valid/ready, header passthrough, bypass, seed load and priming flag.
module scrambler_duplex #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter bit          MODE       = 1'b0,
    parameter bit          BYPASS     = 1'b0,
    parameter logic [57:0] LFSR_SEED  = 58'h3FF_FFFF_FFFF_FFFF
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    scrambler_duplex_if.slave    bus,
    input  logic                 i_bypass,
    input  logic                 i_seed_load,
    input  logic [57:0]          i_seed,
    output logic                 o_primed
);

    localparam int unsigned PRIME_MAX = (58 + DATA_WIDTH - 1) / DATA_WIDTH;
    localparam int unsigned CNT_W     = 2;

    generate
        if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_width_check
            $error("scrambler_duplex: DATA_WIDTH must be 32 or 64");
        end
    endgenerate

    logic [57:0]           lfsr_q;
    logic [57:0]           lfsr_nxt;
    logic [57:0]           walk_s;
    logic                  walk_f;
    logic                  walk_o;
    logic [DATA_WIDTH-1:0] scr_data;
    logic [DATA_WIDTH-1:0] data_q;
    logic [1:0]            hdr_q;
    logic                  valid_q;
    logic                  primed_q;
    logic [CNT_W-1:0]      prime_cnt_q;
    logic                  data_ready;
    logic                  accept;
    logic                  bypass_en;

    assign data_ready       = !valid_q || bus.i_data_ready;
    assign accept           = bus.i_data_valid && data_ready;
    assign bypass_en        = BYPASS || i_bypass;

    assign bus.o_data_ready = data_ready;
    assign bus.o_data_valid = valid_q;
    assign bus.o_data       = data_q;
    assign bus.o_hdr        = hdr_q;
    assign o_primed         = primed_q;

    // Bit-serial walk of the LFSR across the word, bit 0 first on the wire.
    always_comb begin
        walk_s   = lfsr_q;
        walk_f   = 1'b0;
        walk_o   = 1'b0;
        scr_data = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            walk_f      = walk_s[38] ^ walk_s[57];
            walk_o      = bus.i_data[i] ^ walk_f;
            scr_data[i] = walk_o;
            walk_s      = {walk_s[56:0], MODE ? bus.i_data[i] : walk_o};
        end
        lfsr_nxt = walk_s;
    end

    // Output register: holds under backpressure, drops valid once taken with nothing new.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            hdr_q   <= 2'b00;
        end else if (accept) begin
            valid_q <= 1'b1;
            data_q  <= bypass_en ? bus.i_data : scr_data;
            hdr_q   <= bus.i_hdr;
        end else if (bus.i_data_ready) begin
            valid_q <= 1'b0;
        end
    end

    // Seed load takes priority over the word-driven LFSR/counter update.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            lfsr_q      <= LFSR_SEED;
            prime_cnt_q <= '0;
            primed_q    <= 1'b0;
        end else begin
            if (i_seed_load) begin
                lfsr_q <= i_seed;
            end else if (accept && !bypass_en) begin
                lfsr_q <= lfsr_nxt;
            end

            if (i_seed_load) begin
                prime_cnt_q <= '0;
            end else if (MODE && accept && !bypass_en && (prime_cnt_q != CNT_W'(PRIME_MAX))) begin
                prime_cnt_q <= prime_cnt_q + CNT_W'(1);
            end

            if (MODE) begin
                primed_q <= !i_seed_load && (prime_cnt_q == CNT_W'(PRIME_MAX));
            end else begin
                primed_q <= !i_seed_load;
            end
        end
    end

endmodule

// File: tb/tb_scrambler_duplex.sv
// Scoreboard bench for scrambler_duplex: 32/64-bit scramblers and descramblers side by side.
module tb_scrambler_duplex;

    localparam logic [57:0] ONES = 58'h3FF_FFFF_FFFF_FFFF;

    typedef struct {
        logic [63:0] data;
        logic [63:0] mask;
        logic [1:0]  hdr;
    } exp_t;

    logic        i_clk     = 1'b0;
    logic        i_reset_n = 1'b0;
    logic [3:0]  byp;
    logic [3:0]  sl;
    logic [57:0] seed;
    logic [3:0]  primed;

    int          n_checks = 0;
    int          n_fail   = 0;
    exp_t        q0[$];
    exp_t        q1[$];
    exp_t        q2[$];
    exp_t        q3[$];
    logic [57:0] m_s [4];

    scrambler_duplex_if #(.DATA_WIDTH(32)) if0 ();
    scrambler_duplex_if #(.DATA_WIDTH(32)) if1 ();
    scrambler_duplex_if #(.DATA_WIDTH(64)) if2 ();
    scrambler_duplex_if #(.DATA_WIDTH(64)) if3 ();

    scrambler_duplex #(.DATA_WIDTH(32), .MODE(1'b0)) u_scr32 (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .bus(if0), .i_bypass(byp[0]),
        .i_seed_load(sl[0]), .i_seed(seed), .o_primed(primed[0]));
    scrambler_duplex #(.DATA_WIDTH(32), .MODE(1'b1), .LFSR_SEED(58'h0)) u_des32 (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .bus(if1), .i_bypass(byp[1]),
        .i_seed_load(sl[1]), .i_seed(seed), .o_primed(primed[1]));
    scrambler_duplex #(.DATA_WIDTH(64), .MODE(1'b0)) u_scr64 (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .bus(if2), .i_bypass(byp[2]),
        .i_seed_load(sl[2]), .i_seed(seed), .o_primed(primed[2]));
    scrambler_duplex #(.DATA_WIDTH(64), .MODE(1'b1)) u_des64 (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .bus(if3), .i_bypass(byp[3]),
        .i_seed_load(sl[3]), .i_seed(seed), .o_primed(primed[3]));

    always #5 i_clk = ~i_clk;

    function automatic int width_of(input int k);
        return (k < 2) ? 32 : 64;
    endfunction

    function automatic bit desc_of(input int k);
        return (k == 1) || (k == 3);
    endfunction

    // Reference G(x) walk, independent of the DUT.
    function automatic void model(input logic [57:0] s_in, input logic [63:0] d, input int w,
                                  input bit desc, output logic [63:0] o, output logic [57:0] s_out);
        logic [57:0] s;
        logic        f;
        s = s_in;
        o = '0;
        for (int i = 0; i < w; i++) begin
            f    = s[38] ^ s[57];
            o[i] = d[i] ^ f;
            s    = {s[56:0], desc ? d[i] : o[i]};
        end
        s_out = s;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int k, input exp_t e);
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            2:       q2.push_back(e);
            default: q3.push_back(e);
        endcase
    endtask

    task automatic sb_check(input int k, input logic [63:0] d, input logic [1:0] h);
        exp_t        e;
        bit          have;
        logic [63:0] m;
        have = 1'b0;
        case (k)
            0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            2:       if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
            default: if (q3.size() > 0) begin e = q3.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb%0d_unexpected: got word %h expected none", k, d);
        end else begin
            m = e.mask & ((width_of(k) == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF);
            if (m != 64'd0) chk($sformatf("sb%0d_data", k), d & m, e.data & m);
            chk($sformatf("sb%0d_hdr", k), 64'(h), 64'(e.hdr));
        end
    endtask

    // Monitors: a word counts as delivered when valid and ready are both high.
    always @(negedge i_clk) if (i_reset_n && if0.o_data_valid && if0.i_data_ready) sb_check(0, 64'(if0.o_data), if0.o_hdr);
    always @(negedge i_clk) if (i_reset_n && if1.o_data_valid && if1.i_data_ready) sb_check(1, 64'(if1.o_data), if1.o_hdr);
    always @(negedge i_clk) if (i_reset_n && if2.o_data_valid && if2.i_data_ready) sb_check(2, 64'(if2.o_data), if2.o_hdr);
    always @(negedge i_clk) if (i_reset_n && if3.o_data_valid && if3.i_data_ready) sb_check(3, 64'(if3.o_data), if3.o_hdr);

    function automatic logic rdy_of(input int k);
        case (k)
            0:       return if0.o_data_ready;
            1:       return if1.o_data_ready;
            2:       return if2.o_data_ready;
            default: return if3.o_data_ready;
        endcase
    endfunction

    task automatic drive_in(input int k, input logic v, input logic [63:0] d, input logic [1:0] h);
        case (k)
            0:       begin if0.i_data_valid = v; if0.i_data = d[31:0]; if0.i_hdr = h; end
            1:       begin if1.i_data_valid = v; if1.i_data = d[31:0]; if1.i_hdr = h; end
            2:       begin if2.i_data_valid = v; if2.i_data = d;       if2.i_hdr = h; end
            default: begin if3.i_data_valid = v; if3.i_data = d;       if3.i_hdr = h; end
        endcase
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input int k, input logic [63:0] d, input logic [1:0] h, input bit byp_i,
                        input bit sl_i, input logic [57:0] seed_i, input bit use_hand,
                        input logic [63:0] hand, input logic [63:0] mask);
        logic [63:0] o;
        logic [57:0] ns;
        exp_t        e;
        bit          acc;
        int          n;
        model(m_s[k], d, width_of(k), desc_of(k), o, ns);
        e.data = byp_i ? d : (use_hand ? hand : o);
        e.mask = mask;
        e.hdr  = h;
        if (!byp_i) m_s[k] = ns;
        if (sl_i)   m_s[k] = seed_i;
        push(k, e);
        drive_in(k, 1'b1, d, h);
        byp[k] = byp_i;
        sl[k]  = sl_i;
        seed   = seed_i;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 100) begin
            @(negedge i_clk);
            acc = rdy_of(k);
            @(posedge i_clk);
            #1;
            n++;
        end
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL send%0d_timeout: ready stayed 0 for %0d cycles, required 1", k, n);
        end
        drive_in(k, 1'b0, d, h);
        byp[k] = 1'b0;
        sl[k]  = 1'b0;
    endtask

    task automatic s_hand(input int k, input logic [63:0] d, input logic [1:0] h, input logic [63:0] hand);
        send(k, d, h, 1'b0, 1'b0, 58'h0, 1'b1, hand, 64'hFFFF_FFFF_FFFF_FFFF);
    endtask

    task automatic s_model(input int k, input logic [63:0] d, input logic [1:0] h);
        send(k, d, h, 1'b0, 1'b0, 58'h0, 1'b0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() + q1.size() + q2.size() + q3.size()) != 0 && n < 100) begin
            @(posedge i_clk);
            n++;
        end
        @(posedge i_clk);
        #1;
        chk("drain_empty", 64'(q0.size() + q1.size() + q2.size() + q3.size()), 64'd0);
    endtask

    task automatic reset_models();
        m_s[0] = ONES;
        m_s[1] = 58'h0;
        m_s[2] = ONES;
        m_s[3] = ONES;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [57:0] lb_s;
        logic [63:0] sc;
        logic [63:0] lb_mask;
        logic [31:0] pay [5];
        pay = '{32'h1234_5678, 32'hCAFE_F00D, 32'h0F1E_2D3C, 32'hA5A5_5A5A, 32'h00FF_00FF};

        reset_models();
        byp  = '0;
        sl   = '0;
        seed = '0;
        drive_in(0, 1'b0, 64'h0, 2'b00);
        drive_in(1, 1'b0, 64'h0, 2'b00);
        drive_in(2, 1'b0, 64'h0, 2'b00);
        drive_in(3, 1'b0, 64'h0, 2'b00);
        if0.i_data_ready = 1'b1;
        if1.i_data_ready = 1'b1;
        if2.i_data_ready = 1'b1;
        if3.i_data_ready = 1'b1;

        // Reset state
        #3;
        chk("rst_valid", 64'({if3.o_data_valid, if2.o_data_valid, if1.o_data_valid, if0.o_data_valid}), 64'd0);
        chk("rst_data32", 64'(if0.o_data), 64'd0);
        chk("rst_data64", if2.o_data, 64'd0);
        chk("rst_hdr", 64'({if0.o_hdr, if3.o_hdr}), 64'd0);
        chk("rst_primed", 64'(primed), 64'd0);
        @(posedge i_clk); #1;
        i_reset_n = 1'b1;
        @(posedge i_clk); #1;
        @(negedge i_clk);
        chk("primed_after_release", 64'(primed), 64'b0101);
        @(posedge i_clk); #1;

        // Two zero words from the all-ones seed
        s_hand(0, 64'h0, 2'b01, 64'h0);
        chk("t1_latency_valid", 64'(if0.o_data_valid), 64'd1);
        s_hand(0, 64'h0, 2'b01, 64'h03FF_FF80);
        drain();

        // Backpressure: output full for three cycles
        if0.i_data_ready = 1'b0;
        fork
            begin
                s_model(0, 64'h1111_2222, 2'b10);
                s_model(0, 64'h3333_4444, 2'b10);
                s_model(0, 64'h5555_6666, 2'b10);
            end
            begin
                @(posedge i_clk); #1;
                repeat (3) begin
                    @(negedge i_clk);
                    chk("t2_ready_low", 64'(if0.o_data_ready), 64'd0);
                    chk("t2_hold", 64'(if0.o_data), q0[0].data);
                end
                @(posedge i_clk); #1;
                if0.i_data_ready = 1'b1;
            end
        join
        drain();

        // Bypassed word mid-stream leaves the LFSR untouched
        s_model(0, 64'h0BAD_F00D, 2'b01);
        send(0, 64'hDEAD_BEEF, 2'b10, 1'b1, 1'b0, 58'h0, 1'b1, 64'hDEAD_BEEF, 64'hFFFF_FFFF_FFFF_FFFF);
        s_model(0, 64'h1357_9BDF, 2'b01);
        drain();

        // Loopback: scrambled stream into a descrambler seeded with zero
        lb_s = ONES;
        for (int i = 0; i < 5; i++) begin
            model(lb_s, 64'(pay[i]), 32, 1'b0, sc, lb_s);
            lb_mask = (i == 0) ? 64'h0 : (i == 1) ? 64'hFC00_0000 : 64'hFFFF_FFFF_FFFF_FFFF;
            send(1, sc, 2'b10, 1'b0, 1'b0, 58'h0, 1'b1, 64'(pay[i]), lb_mask);
            if (i < 2) begin
                @(negedge i_clk);
                chk("t3_primed_early", 64'(primed[1]), 64'd0);
                if (i == 1) begin
                    @(negedge i_clk);
                    chk("t3_primed", 64'(primed[1]), 64'd1);
                end
                @(posedge i_clk); #1;
            end
        end
        drain();

        // 64-bit seed load coincident with an accept (scramble)
        s_hand(2, 64'h0, 2'b01, 64'h03FF_FF80_0000_0000);
        send(2, 64'h0, 2'b10, 1'b0, 1'b1, ONES, 1'b0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF);
        s_hand(2, 64'h0, 2'b01, 64'h03FF_FF80_0000_0000);
        drain();

        // 64-bit seed load in descramble: primed drops, returns after one word
        s_model(3, 64'h0123_4567_89AB_CDEF, 2'b10);
        @(negedge i_clk);
        chk("t5_primed_early", 64'(primed[3]), 64'd0);
        @(negedge i_clk);
        chk("t5_primed", 64'(primed[3]), 64'd1);
        @(posedge i_clk); #1;
        send(3, 64'hFEDC_BA98_7654_3210, 2'b01, 1'b0, 1'b1, 58'h2AA_AAAA_5555_AAAA, 1'b0, 64'h0,
             64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge i_clk);
        chk("t5_primed_drop", 64'(primed[3]), 64'd0);
        @(posedge i_clk); #1;
        s_model(3, 64'h0F0F_F0F0_3C3C_C3C3, 2'b10);
        @(negedge i_clk);
        chk("t5_primed_wait", 64'(primed[3]), 64'd0);
        @(negedge i_clk);
        chk("t5_primed_back", 64'(primed[3]), 64'd1);
        @(posedge i_clk); #1;
        drain();

        // Asynchronous reset with a word held at the output
        if0.i_data_ready = 1'b0;
        s_model(0, 64'hA5A5_0F0F, 2'b10);
        @(negedge i_clk);
        chk("t6_valid_held", 64'(if0.o_data_valid), 64'd1);
        #2;
        i_reset_n = 1'b0;
        #1;
        chk("t6_valid_async", 64'(if0.o_data_valid), 64'd0);
        chk("t6_data_async", 64'(if0.o_data), 64'd0);
        chk("t6_hdr_async", 64'(if0.o_hdr), 64'd0);
        chk("t6_primed_async", 64'(primed[0]), 64'd0);
        q0.delete();
        reset_models();
        @(posedge i_clk); #1;
        i_reset_n = 1'b1;
        if0.i_data_ready = 1'b1;
        s_hand(0, 64'h0, 2'b01, 64'h0);
        s_hand(0, 64'h0, 2'b01, 64'h03FF_FF80);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
